// File: rtl/video_out_tap_generator.sv
// Horizontal scaler front end: walks one line-buffer line with a 6-bit phase
// accumulator and emits registered (coeff, tap0, tap1) triples for video_out_bilinear.
module video_out_tap_generator #(
  parameter int SRC_WIDTH = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [6:0]           step,
  input  logic [10:0]          dst_width,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_enable,
  output logic [ADDR_BITS-1:0] rd_address,
  input  logic [5:0]           rd_data,
  output logic [5:0]           coeff,
  output logic [5:0]           tap0,
  output logic [5:0]           tap1,
  output logic                 out_valid
);

  localparam int PTR_BITS = ADDR_BITS + 1;
  localparam logic [PTR_BITS-1:0] PTR_END = PTR_BITS'(SRC_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [6:0]          step_q;
  logic [10:0]         width_q;
  logic [10:0]         emitted;
  logic [5:0]          frac;
  logic [PTR_BITS-1:0] fetch_ptr;
  logic                in_flight;
  logic [5:0]          queue      [4];
  logic [5:0]          queue_next [4];
  logic [2:0]          count;
  logic [2:0]          count_next;
  logic [2:0]          count_pop;

  logic       accept;
  logic       active;
  logic       fetch_left;
  logic       tail_final;
  logic       have_tap1;
  logic       ready;
  logic       emit;
  logic       last_emit;
  logic       carry;
  logic       pop;
  logic       fetch;
  logic [6:0] phase_sum;
  logic [2:0] occupancy;

  always_comb begin
    accept     = (state == IDLE) && !done && start;
    active     = (state == FILL) || (state == RUN);
    fetch_left = fetch_ptr < PTR_END;
    // Once the last source pixel has landed, a lone head entry doubles as tap1 (edge replicate).
    tail_final = !fetch_left && !in_flight;
    have_tap1  = (count >= 3'd2) || (tail_final && (count != 3'd0));
    ready      = (count != 3'd0) && have_tap1;
    emit       = active && ready && (emitted != width_q);
    last_emit  = emit && (emitted == (width_q - 11'd1));
    phase_sum  = {1'b0, frac} + step_q;
    carry      = phase_sum[6];
    pop        = emit && carry && (count >= 3'd2);
    occupancy  = count + 3'(in_flight) - 3'(pop);
    fetch      = active && fetch_left && (occupancy < 3'd4);
    rd_enable  = fetch;
    rd_address = fetch_ptr[ADDR_BITS-1:0];
  end

  always_comb begin
    queue_next = queue;
    if (pop) begin
      queue_next[0] = queue[1];
      queue_next[1] = queue[2];
      queue_next[2] = queue[3];
    end
    count_pop  = count - 3'(pop);
    count_next = count_pop;
    if (in_flight && active) begin
      queue_next[count_pop[1:0]] = rd_data;
      count_next                 = count_pop + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (dst_width == 11'd0) ? FINISH : FILL;
        end
      end
      FILL: begin
        if (last_emit) begin
          state_next = FINISH;
        end else if (ready) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_emit) begin
          state_next = FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      coeff     <= '0;
      tap0      <= '0;
      tap1      <= '0;
      step_q    <= '0;
      width_q   <= '0;
      emitted   <= '0;
      frac      <= '0;
      fetch_ptr <= '0;
      in_flight <= 1'b0;
      count     <= '0;
      queue     <= '{default: '0};
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state == FINISH);
      out_valid <= emit;
      in_flight <= fetch;
      count     <= count_next;
      queue     <= queue_next;
      if (fetch) begin
        fetch_ptr <= fetch_ptr + 1'b1;
      end
      if (emit) begin
        coeff   <= frac;
        tap0    <= queue[0];
        tap1    <= (count >= 3'd2) ? queue[1] : queue[0];
        frac    <= phase_sum[5:0];
        emitted <= emitted + 11'd1;
      end
      if (accept) begin
        step_q    <= (step > 7'd64) ? 7'd64 : step;
        width_q   <= dst_width;
        emitted   <= '0;
        frac      <= '0;
        fetch_ptr <= '0;
        count     <= '0;
      end
    end
  end

endmodule

// File: doc/video_out_tap_generator.md
Name: video_out_tap_generator

Overview:
Horizontal scaler front end that feeds video_out_bilinear.
- On a start pulse it walks one source line held in an external synchronous line-buffer RAM using a 6-bit fractional phase accumulator.
- Per destination pixel it emits a registered (coeff, tap0, tap1) triple plus out_valid, at up to one triple per clock.
- It sits between the line buffer and video_out_bilinear; coeff/tap0/tap1 connect directly to that block's ports.

Parameters:
SRC_WIDTH, 256, number of source pixels per line (2..2^ADDR_BITS).
ADDR_BITS, 8, line-buffer address width.

Ports:
clk  input  1  system clock (42.95454 MHz).
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a line; ignored while busy=1.
step  input  7  phase increment per output pixel, 64 = 1.0 source pixel; latched at start.
dst_width  input  11  number of output pixels for the line; latched at start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the line is finished.
rd_enable  output  1  line-buffer read strobe.
rd_address  output  ADDR_BITS  line-buffer read address.
rd_data  input  6  line-buffer data; valid the cycle after rd_enable/rd_address are presented.
coeff  output  6  interpolation weight for tap1; 0 = pure tap0.
tap0  output  6  source pixel src[i].
tap1  output  6  source pixel src[i+1].
out_valid  output  1  coeff/tap0/tap1 hold a new destination pixel.

Behaviour:
- Reset (async, any time, including mid-line):
  - busy, done, rd_enable, out_valid = 0; coeff, tap0, tap1, rd_address = 0.
  - Prefetch queue empty; state IDLE.
- States:
  - IDLE --start--> FILL: latch step (values >64 saturate to 64), latch dst_width, set i=0 and frac=0, fetch pointer=0.
  - FILL --queue holds src[0],src[1]--> RUN.
  - RUN --dst_width triples emitted--> FINISH.
  - FINISH --> IDLE, with done=1 and busy=0 in that cycle.
- dst_width=0: IDLE→FINISH directly. done pulses 2 cycles after start with no out_valid.
- Prefetch:
  - 4-entry queue of source pixels, counting in-flight reads.
  - rd_enable=1 with rd_address=fetch pointer whenever a slot is free and fetch pointer ≤ SRC_WIDTH-1; the pointer then increments.
  - After src[SRC_WIDTH-1] is fetched, reads stop. Any index ≥ SRC_WIDTH reads as src[SRC_WIDTH-1] (edge replicate).
- RUN, per emitted output (registered, out_valid=1):
  - coeff=frac, tap0=src[i], tap1=src[min(i+1, SRC_WIDTH-1)].
  - Then {carry,frac_next} = frac + step (7-bit sum); i advances by carry (max 1 because step ≤ 64); the queue pops one pixel on carry.
- If the needed pixel is not yet in the queue, out_valid=0 for that cycle (bubble) and phase does not advance.
- With step ≤ 64 there are no bubbles after the first out_valid: dst_width consecutive out_valid cycles.
- Latency: first out_valid ≤ 6 cycles after the start edge.
- done asserts the cycle after the last out_valid; busy falls in the same cycle.
- start while busy (including the cycle of done) is ignored.
- coeff/tap0/tap1 hold their last values while out_valid=0.
- No output depends combinationally on an input.

Test Plan:
Bench setup: SRC_WIDTH=8, RAM src[n]=8n, video_out_bilinear attached.
1. step=64, dst_width=8 -> 8 consecutive valids, coeff=0 each, (tap0,tap1)=(0,8),(8,16),…,(48,56),(56,56); done 1 cycle after last valid.
2. step=32, dst_width=16 -> coeff 0,32,0,32…; taps (0,8),(0,8),(8,16),(8,16)…,(56,56),(56,56); no bubbles.
3. step=0, dst_width=5 -> 5 valids, all coeff=0, taps (0,8); step=100 behaves exactly as step=64 (scenario 1).
4. step=21, dst_width=24 -> coeff sequence 0,21,42,63,20,41,62,19…; i increments exactly on wrap; last taps clamp to (56,56).
5. Reset pulse after 3rd valid -> out_valid/busy/rd_enable drop asynchronously; next start reproduces scenario 1 from pixel 0.
6. start pulsed while busy and on the done cycle -> ignored; dst_width=0 -> done 2 cycles after start, zero valids.
